// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a valid/ready handshake and a two-entry skid buffer.
// The ready output is decoded from registered state only. Also provides a synchronous
// flush and a saturating stall counter.
module pipe_stage_skid #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 NEG_EDGE  = 1,
  parameter int                 CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             stall_clr_i,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load_main, load_skid;
  logic             in_fire, out_fire;
  logic             clk_act;

  // Every register in the stage runs from one clock whose polarity is fixed at elaboration.
  assign clk_act = (NEG_EDGE != 0) ? ~clk : clk;

  assign out_valid_o = (state_q != EMPTY);
  assign in_ready_o  = (state_q != FULL);
  assign out_data_o  = main_q;
  assign stall_cnt_o = cnt_q;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  // NOTE: every output of this block gets a default first so that no path infers a latch.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d   = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Squash wins over everything; any beat accepted this cycle is dropped.
    if (flush_i) begin
      state_d   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_act or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // The data registers take a reset value, so a consumer never sees X after reset.
  always_ff @(posedge clk_act or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      if (load_main) main_q <= (state_q == FULL) ? skid_q : in_data_i;
      if (load_skid) skid_q <= in_data_i;
    end
  end

  // Counts cycles where a beat is offered but refused downstream; sticks at all-ones.
  always_ff @(posedge clk_act or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall_clr_i) begin
      cnt_q <= '0;
    end else if (out_valid_o && !out_ready_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: falling-edge instance, 4-bit counter instance,
// and a rising-edge instance.
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // u0: default parameters (falling edge)
  logic        u0_flush, u0_in_valid, u0_in_ready, u0_out_valid, u0_out_ready, u0_clr;
  logic [31:0] u0_in_data, u0_out_data;
  logic [15:0] u0_cnt;
  // u1: CNT_W=4
  logic        u1_flush, u1_in_valid, u1_in_ready, u1_out_valid, u1_out_ready, u1_clr;
  logic [31:0] u1_in_data, u1_out_data;
  logic [3:0]  u1_cnt;
  // u2: rising edge
  logic        u2_flush, u2_in_valid, u2_in_ready, u2_out_valid, u2_out_ready, u2_clr;
  logic [31:0] u2_in_data, u2_out_data;
  logic [15:0] u2_cnt;

  logic [31:0] sb0[$];
  logic [31:0] sb2[$];

  pipe_stage_skid u0 (
    .clk(clk), .rst_n(rst_n), .flush_i(u0_flush),
    .in_valid_i(u0_in_valid), .in_ready_o(u0_in_ready), .in_data_i(u0_in_data),
    .out_valid_o(u0_out_valid), .out_ready_i(u0_out_ready), .out_data_o(u0_out_data),
    .stall_clr_i(u0_clr), .stall_cnt_o(u0_cnt)
  );

  pipe_stage_skid #(.CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .flush_i(u1_flush),
    .in_valid_i(u1_in_valid), .in_ready_o(u1_in_ready), .in_data_i(u1_in_data),
    .out_valid_o(u1_out_valid), .out_ready_i(u1_out_ready), .out_data_o(u1_out_data),
    .stall_clr_i(u1_clr), .stall_cnt_o(u1_cnt)
  );

  pipe_stage_skid #(.NEG_EDGE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .flush_i(u2_flush),
    .in_valid_i(u2_in_valid), .in_ready_o(u2_in_ready), .in_data_i(u2_in_data),
    .out_valid_o(u2_out_valid), .out_ready_i(u2_out_ready), .out_data_o(u2_out_data),
    .stall_clr_i(u2_clr), .stall_cnt_o(u2_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // u0 monitor: a transfer is decided at the falling edge, so sample on the rising edge.
  always @(posedge clk) begin
    if (rst_n && u0_out_valid && u0_out_ready) begin
      if (sb0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL u0_unexpected_beat: got %h, expected no beat", u0_out_data);
      end else begin
        check("u0_beat", u0_out_data, sb0.pop_front());
      end
    end
  end

  // u2 monitor: u2 updates on rising edges, so sample on the falling edge.
  always @(negedge clk) begin
    if (rst_n && u2_out_valid && u2_out_ready) begin
      if (sb2.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL u2_unexpected_beat: got %h, expected no beat", u2_out_data);
      end else begin
        check("u2_beat", u2_out_data, sb2.pop_front());
      end
    end
  end

  // Hold a beat on u0 until the stage accepts it, then record the expected output.
  task automatic push0(input logic [31:0] d);
    int waited;
    waited = 0;
    u0_in_valid = 1'b1;
    u0_in_data  = d;
    @(posedge clk);
    while (!u0_in_ready && waited < 100) begin
      waited++;
      @(posedge clk);
    end
    if (!u0_in_ready) check("u0_push_timeout", 32'(u0_in_ready), 32'd1);
    sb0.push_back(d);
    @(negedge clk);
    #1;
    u0_in_valid = 1'b0;
  endtask

  task automatic drain0();
    for (int i = 0; i < 50 && sb0.size() != 0; i++) @(negedge clk);
    check("u0_drain_left", sb0.size(), 32'd0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        snap_v;
    logic [31:0] snap_d;
    rst_n = 1'b0;
    {u0_flush, u0_in_valid, u0_out_ready, u0_clr, u0_in_data} = '0;
    {u1_flush, u1_in_valid, u1_out_ready, u1_clr, u1_in_data} = '0;
    {u2_flush, u2_in_valid, u2_out_ready, u2_clr, u2_in_data} = '0;
    #12;
    check("rst_out_valid", 32'(u0_out_valid), 32'd0);
    check("rst_in_ready",  32'(u0_in_ready),  32'd1);
    check("rst_out_data",  u0_out_data,       32'd0);
    check("rst_stall_cnt", 32'(u0_cnt),       32'd0);
    #5 rst_n = 1'b1;
    @(negedge clk);
    #1;

    // 1. streaming
    u0_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push0(32'(i));
      check("t1_in_ready", 32'(u0_in_ready), 32'd1);
    end
    drain0();
    check("t1_empty_after", 32'(u0_out_valid), 32'd0);
    check("t1_stall_cnt", 32'(u0_cnt), 32'd0);

    // 2. backpressure into the skid entry
    u0_out_ready = 1'b0;
    push0(32'h11);
    push0(32'h22);
    check("t2_full_in_ready", 32'(u0_in_ready), 32'd0);
    check("t2_full_out_valid", 32'(u0_out_valid), 32'd1);
    check("t2_head_data", u0_out_data, 32'h11);
    check("t2_stall_cnt1", 32'(u0_cnt), 32'd1);
    u0_in_valid = 1'b1;
    u0_in_data  = 32'h33;
    repeat (3) @(negedge clk);
    #1;
    check("t2_held_in_ready", 32'(u0_in_ready), 32'd0);
    check("t2_stall_cnt4", 32'(u0_cnt), 32'd4);
    u0_out_ready = 1'b1;
    push0(32'h33);
    drain0();
    check("t2_empty_after", 32'(u0_out_valid), 32'd0);

    // 3. flush drops both the held beat and the beat offered alongside it
    u0_out_ready = 1'b0;
    push0(32'h55);
    u0_in_valid = 1'b1;
    u0_in_data  = 32'h44;
    u0_flush    = 1'b1;
    @(negedge clk);
    #1;
    u0_in_valid = 1'b0;
    u0_flush    = 1'b0;
    sb0.delete();
    check("t3_out_valid", 32'(u0_out_valid), 32'd0);
    check("t3_in_ready", 32'(u0_in_ready), 32'd1);
    check("t3_data_kept", u0_out_data, 32'h55);
    u0_out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("t3_still_empty", 32'(u0_out_valid), 32'd0);

    // 4. async reset between edges
    u0_out_ready = 1'b0;
    push0(32'hA);
    push0(32'hB);
    check("t4_full", 32'(u0_in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_out_valid", 32'(u0_out_valid), 32'd0);
    check("t4_rst_in_ready", 32'(u0_in_ready), 32'd1);
    check("t4_rst_out_data", u0_out_data, 32'd0);
    check("t4_rst_stall_cnt", 32'(u0_cnt), 32'd0);
    sb0.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;

    // 5. saturating counter on the 4-bit instance
    u1_in_valid = 1'b1;
    u1_in_data  = 32'h77;
    @(negedge clk);
    #1;
    u1_in_valid = 1'b0;
    check("t5_cnt_start", 32'(u1_cnt), 32'd0);
    repeat (14) @(negedge clk);
    #1;
    check("t5_cnt_14", 32'(u1_cnt), 32'd14);
    repeat (6) @(negedge clk);
    #1;
    check("t5_cnt_sat", 32'(u1_cnt), 32'd15);
    repeat (5) @(negedge clk);
    #1;
    check("t5_cnt_held", 32'(u1_cnt), 32'd15);
    check("t5_data", u1_out_data, 32'h77);
    u1_clr = 1'b1;
    @(negedge clk);
    #1;
    u1_clr = 1'b0;
    check("t5_cnt_clr", 32'(u1_cnt), 32'd0);
    @(negedge clk);
    #1;
    check("t5_cnt_restart", 32'(u1_cnt), 32'd1);

    // 6. rising-edge instance: stream, and nothing moves on falling edges
    u2_out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 8; i++) begin
      u2_in_valid = 1'b1;
      u2_in_data  = 32'(i) | 32'h600;
      sb2.push_back(32'(i) | 32'h600);
      snap_v = u2_out_valid;
      snap_d = u2_out_data;
      @(negedge clk);
      check("t6_fall_hold_valid", 32'(u2_out_valid), 32'(snap_v));
      check("t6_fall_hold_data", u2_out_data, snap_d);
      check("t6_in_ready", 32'(u2_in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    u2_in_valid = 1'b0;
    for (int i = 0; i < 50 && sb2.size() != 0; i++) @(posedge clk);
    check("u2_drain_left", sb2.size(), 32'd0);
    #1;
    check("t6_empty_after", 32'(u2_out_valid), 32'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
